// File: rtl/symbol_scheduler_if.sv
// ----------------------------------------------------------------------------
// symbol_scheduler_if
// Symbol handshake between an upstream symbol source and symbol_scheduler.
//   sym_valid  upstream has a symbol on sym_data
//   sym_data   2-bit symbol code (waveform ROM select)
//   sym_ready  scheduler queue can take a symbol this cycle
// master: the symbol source.  slave: the scheduler.
// ----------------------------------------------------------------------------
interface symbol_scheduler_if;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;

    modport master (output sym_valid, output sym_data, input  sym_ready);
    modport slave  (input  sym_valid, input  sym_data, output sym_ready);
endinterface

// File: rtl/symbol_scheduler.sv
// ----------------------------------------------------------------------------
// symbol_scheduler
// Queues 2-bit symbol codes and plays each one out as SAMPLES consecutive
// waveform-ROM addresses (rom_sel, sample_idx). Symbols play back to back
// with no gap while the queue has data; running dry at the end of a symbol
// sets the sticky underrun flag.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        1 = play, 0 = freeze the current sample position
//   sym           symbol handshake (slave side: sym_valid, sym_data, sym_ready)
//   clr_underrun  synchronous clear of underrun (a same-edge set wins)
//   rom_sel       waveform ROM select of the symbol being played
//   sample_idx    ROM address within the symbol, 0..SAMPLES-1
//   sample_valid  rom_sel/sample_idx address a live sample this cycle
//   sym_start     one-cycle pulse with sample_idx 0 of each new symbol
//   fifo_count    number of queued symbols, 0..FIFO_DEPTH
//   underrun      sticky: playback reached the end of a symbol with no successor
// ----------------------------------------------------------------------------
module symbol_scheduler #(
    parameter int FIFO_DEPTH = 4,   // power of two, 2..16
    parameter int SAMPLES    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    symbol_scheduler_if.slave   sym,
    input  logic                clr_underrun,
    output logic [1:0]          rom_sel,
    output logic [3:0]          sample_idx,
    output logic                sample_valid,
    output logic                sym_start,
    output logic [4:0]          fifo_count,
    output logic                underrun
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);
    localparam logic [3:0] LAST_IDX  = 4'(SAMPLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]       state;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic pop;
    logic at_last;
    logic have_sym;

    // Readiness comes from the registered count only, so a pop on the same
    // edge never opens a slot for a push while the queue is full.
    assign sym.sym_ready = (fifo_count < DEPTH_CNT);

    assign push     = sym.sym_valid & sym.sym_ready;
    assign at_last  = (sample_idx == LAST_IDX);
    assign have_sym = (fifo_count != 5'd0);

    // A symbol is taken when playback starts from idle, or when the current
    // symbol finishes its last sample. Pre-edge count is used, so a symbol
    // pushed on the same edge cannot rescue an end-of-symbol underrun.
    assign pop = enable & have_sym & ((state == IDLE) | at_last);

    // NOTE: queue storage has no reset; pointers and count define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sym.sym_data;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rom_sel      <= 2'd0;
            sample_idx   <= 4'd0;
            sample_valid <= 1'b0;
            sym_start    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            sym_start    <= 1'b0;
            // Clear first; an underrun set below on the same edge overrides it.
            if (clr_underrun) underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        state        <= PLAY;
                        rom_sel      <= mem[rd_ptr];
                        sample_idx   <= 4'd0;
                        sample_valid <= 1'b1;
                        sym_start    <= 1'b1;
                    end
                end
                PLAY: begin
                    // enable=0 falls through: position frozen, outputs invalid.
                    if (enable) begin
                        if (!at_last) begin
                            sample_idx   <= sample_idx + 4'd1;
                            sample_valid <= 1'b1;
                        end else if (pop) begin
                            rom_sel      <= mem[rd_ptr];
                            sample_idx   <= 4'd0;
                            sample_valid <= 1'b1;
                            sym_start    <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            underrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
